blackjack_display: RTL

Downstream display stage for `blackjack_core`. It continuously samples `user_total`, `dealer_total` and `balance` and converts each to BCD with a shared serial double-dabble converter. It then time-multiplexes the eight resulting digits onto a common-anode 7-segment display. The block has no handshake with the core and only observes the core's registered outputs.

---
 rtl/blackjack_pkg.sv | 57 +++++
 rtl/bin2bcd_serial.sv | 41 ++++
 rtl/blackjack_display.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/blackjack_pkg.sv
// Shared constants for the blackjack display path: segment patterns, digit slots, converter encodings.
package blackjack_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] DIG_BAL_ONES      = 3'd0;
    localparam logic [2:0] DIG_BAL_TENS      = 3'd1;
    localparam logic [2:0] DIG_BAL_HUNDREDS  = 3'd2;
    localparam logic [2:0] DIG_BAL_THOUSANDS = 3'd3;
    localparam logic [2:0] DIG_DLR_ONES      = 3'd4;
    localparam logic [2:0] DIG_DLR_TENS      = 3'd5;
    localparam logic [2:0] DIG_USR_ONES      = 3'd6;
    localparam logic [2:0] DIG_USR_TENS      = 3'd7;

    typedef enum logic [1:0] {
        SRC_USER   = 2'd0,
        SRC_DEALER = 2'd1,
        SRC_BAL    = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SHIFT = 2'd1,
        S_STORE = 2'd2
    } conv_state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] add3_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: 10-bit binary to 4 BCD digits, 10 shifts after the start cycle.
// done is high during the final shift cycle; no backpressure, a new start restarts it.
module bin2bcd_serial
    import blackjack_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic [15:0] bcd,
    output logic        done
);

    logic [9:0]  sr;
    logic [3:0]  cnt;
    logic [15:0] bcd_adj;

    always_comb begin
        bcd_adj = {add3_adj(bcd[15:12]), add3_adj(bcd[11:8]),
                   add3_adj(bcd[7:4]),   add3_adj(bcd[3:0])};
    end

    assign done = (cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (start) begin
            sr  <= bin;
            bcd <= '0;
            cnt <= 4'd10;
        end else if (cnt != 4'd0) begin
            bcd <= (bcd_adj << 1) | {15'd0, sr[9]};
            sr  <= sr << 1;
            cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: rtl/blackjack_display.sv
// Round-robin BCD conversion of user/dealer/balance (12-cycle slots) plus 8-digit 7-seg scan, 1-cycle seg/an latency.
// No handshake with the core; BLANK_LEADING_ZERO_EN blanks leading zero digits.
module blackjack_display
    import blackjack_pkg::*;
#(
    parameter int REFRESH_DIV = 25000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  user_total,
    input  logic [5:0]  dealer_total,
    input  logic [9:0]  balance,
    output logic [7:0]  user_bcd,
    output logic [7:0]  dealer_bcd,
    output logic [15:0] balance_bcd,
    output logic        conv_valid,
    output logic [6:0]  seg,
    output logic [7:0]  an
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    conv_state_e state, state_nxt;
    src_e        sel;
    logic        conv_start, conv_store, conv_done;
    logic [9:0]  conv_bin;
    logic [15:0] conv_bcd;

    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (conv_done) state_nxt = S_STORE;
            S_STORE: state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        conv_start = (state == S_LOAD);
        conv_store = (state == S_STORE);
    end

    always_comb begin
        case (sel)
            SRC_USER:   conv_bin = {4'd0, user_total};
            SRC_DEALER: conv_bin = {4'd0, dealer_total};
            default:    conv_bin = balance;
        endcase
    end

    bin2bcd_serial u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sel         <= SRC_USER;
            user_bcd    <= '0;
            dealer_bcd  <= '0;
            balance_bcd <= '0;
            conv_valid  <= 1'b0;
        end else begin
            conv_valid <= conv_store;
            if (conv_store) begin
                case (sel)
                    SRC_USER: begin
                        user_bcd <= conv_bcd[7:0];
                        sel      <= SRC_DEALER;
                    end
                    SRC_DEALER: begin
                        dealer_bcd <= conv_bcd[7:0];
                        sel        <= SRC_BAL;
                    end
                    default: begin
                        balance_bcd <= conv_bcd;
                        sel         <= SRC_USER;
                    end
                endcase
            end
        end
    end

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       dig_idx;
    logic [3:0]       dig_nib;
    logic             dig_blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            dig_idx <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            dig_idx <= dig_idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        dig_nib   = 4'd0;
        dig_blank = 1'b0;
        case (dig_idx)
            DIG_BAL_ONES:      dig_nib = balance_bcd[3:0];
            DIG_BAL_TENS:      dig_nib = balance_bcd[7:4];
            DIG_BAL_HUNDREDS:  dig_nib = balance_bcd[11:8];
            DIG_BAL_THOUSANDS: dig_nib = balance_bcd[15:12];
            DIG_DLR_ONES:      dig_nib = dealer_bcd[3:0];
            DIG_DLR_TENS:      dig_nib = dealer_bcd[7:4];
            DIG_USR_ONES:      dig_nib = user_bcd[3:0];
            default:           dig_nib = user_bcd[7:4];
        endcase
`ifdef BLANK_LEADING_ZERO_EN
        // A digit is a leading zero when it and every more significant digit are zero.
        case (dig_idx)
            DIG_BAL_TENS:      dig_blank = (balance_bcd[15:4] == 12'd0);
            DIG_BAL_HUNDREDS:  dig_blank = (balance_bcd[15:8] == 8'd0);
            DIG_BAL_THOUSANDS: dig_blank = (balance_bcd[15:12] == 4'd0);
            DIG_DLR_TENS:      dig_blank = (dealer_bcd[7:4] == 4'd0);
            DIG_USR_TENS:      dig_blank = (user_bcd[7:4] == 4'd0);
            default:           dig_blank = 1'b0;
        endcase
`else
        dig_blank = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= 8'hFF;
        end else begin
            an  <= ~(8'd1 << dig_idx);
            seg <= dig_blank ? SEG_BLANK : seg_decode(dig_nib);
        end
    end

endmodule
